// File: rtl/ibex_neur_mac_array.sv
// Mixed-precision MAC engine for the Ibex EX stage: lane dot-products into
// NUM_ACC accumulators, with a shift/ReLU/saturate/pack readout on GET.
module ibex_neur_mac_array #(
    parameter int unsigned NUM_ACC = 4,
    parameter int unsigned ACC_W   = 40,
    parameter bit          SAT_ACC = 1'b1,
    localparam int unsigned SEL_W  = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             op_valid_i,
    input  logic [1:0]       op_i,
    input  logic [1:0]       mode_i,
    input  logic [SEL_W-1:0] acc_sel_i,
    input  logic [31:0]      weights_i,
    input  logic [31:0]      input_val_i,
    input  logic [31:0]      bias_i,
    input  logic [4:0]       shift_i,
    input  logic             relu_en_i,
    input  logic [1:0]       out_mode_i,
    input  logic [3:0]       position_i,
    input  logic [31:0]      pack_i,
    output logic [31:0]      result_o,
    output logic             res_valid_o,
    output logic             busy_o
);

    typedef enum logic [1:0] {
        OP_MAC  = 2'b00,
        OP_BIAS = 2'b01,
        OP_GET  = 2'b10,
        OP_CLR  = 2'b11
    } op_e;

    typedef struct packed {
        op_e              op;
        logic [SEL_W-1:0] sel;
        logic [31:0]      bias;
        logic [4:0]       shift;
        logic             relu;
        logic [1:0]       out_mode;
        logic [3:0]       position;
        logic [31:0]      pack;
    } ctrl_t;

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    // Signed dot-product of the packed lanes selected by the input precision.
    function automatic logic signed [32:0] lane_sum(input logic [1:0] mode,
                                                    input logic [31:0] w,
                                                    input logic [31:0] x);
        logic signed [32:0] sum;
        sum = '0;
        case (mode)
            2'b00: for (int i = 0; i < 2; i++)
                sum += 33'($signed(w[i*16 +: 16])) * 33'($signed(x[i*16 +: 16]));
            2'b01: for (int i = 0; i < 4; i++)
                sum += 33'($signed(w[i*8 +: 8])) * 33'($signed(x[i*8 +: 8]));
            2'b10: for (int i = 0; i < 8; i++)
                sum += 33'($signed(w[i*4 +: 4])) * 33'($signed(x[i*4 +: 4]));
            default: for (int i = 0; i < 16; i++)
                sum += 33'($signed(w[i*2 +: 2])) * 33'($signed(x[i*2 +: 2]));
        endcase
        return sum;
    endfunction

    logic               s1_valid_q, s2_valid_q;
    ctrl_t              s1_ctrl_q, s2_ctrl_q;
    logic [1:0]         s1_mode_q;
    logic [31:0]        s1_w_q, s1_x_q;
    logic signed [32:0] s2_sum_q;

    logic signed [ACC_W-1:0] acc_q [NUM_ACC];
    logic signed [ACC_W-1:0] acc_d [NUM_ACC];
    logic signed [ACC_W-1:0] acc_rd, sum_ext, bias_ext, mac_res;
    logic [ACC_W:0]          add_w;

    logic signed [ACC_W-1:0] shifted, v, sat_hi, sat_lo;
    logic [31:0]             field, lane_mask, get_res;
    int unsigned             ow, slot;
    logic                    sel_ok;

    logic [31:0] result_q;
    logic        res_valid_q, busy_q;

    // S1: capture the op as issued.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_q <= 1'b0;
            s1_ctrl_q  <= '0;
            s1_mode_q  <= '0;
            s1_w_q     <= '0;
            s1_x_q     <= '0;
        end else begin
            s1_valid_q <= op_valid_i;
            if (op_valid_i) begin
                s1_ctrl_q <= '{op: op_e'(op_i), sel: acc_sel_i, bias: bias_i,
                               shift: shift_i, relu: relu_en_i, out_mode: out_mode_i,
                               position: position_i, pack: pack_i};
                s1_mode_q <= mode_i;
                s1_w_q    <= weights_i;
                s1_x_q    <= input_val_i;
            end
        end
    end

    // S2: lane sum registered alongside the pass-through control.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s2_valid_q <= 1'b0;
            s2_ctrl_q  <= '0;
            s2_sum_q   <= '0;
        end else begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_ctrl_q <= s1_ctrl_q;
                s2_sum_q  <= lane_sum(s1_mode_q, s1_w_q, s1_x_q);
            end
        end
    end

    assign sum_ext  = {{(ACC_W-33){s2_sum_q[32]}}, s2_sum_q};
    assign bias_ext = {{(ACC_W-32){s2_ctrl_q.bias[31]}}, s2_ctrl_q.bias};
    assign sel_ok   = 32'(s2_ctrl_q.sel) < NUM_ACC;

    // Accumulator read/update for the op in S2; out-of-range selects match nothing.
    always_comb begin
        acc_d  = acc_q;
        acc_rd = '0;
        for (int unsigned k = 0; k < NUM_ACC; k++)
            if (32'(s2_ctrl_q.sel) == k) acc_rd = acc_q[k];
        add_w = {acc_rd[ACC_W-1], acc_rd} + {sum_ext[ACC_W-1], sum_ext};
        if (SAT_ACC && (add_w[ACC_W] != add_w[ACC_W-1]))
            mac_res = add_w[ACC_W] ? ACC_MIN : ACC_MAX;
        else
            mac_res = add_w[ACC_W-1:0];
        if (s2_valid_q) begin
            case (s2_ctrl_q.op)
                OP_MAC:  for (int unsigned k = 0; k < NUM_ACC; k++)
                    if (32'(s2_ctrl_q.sel) == k) acc_d[k] = mac_res;
                OP_BIAS: for (int unsigned k = 0; k < NUM_ACC; k++)
                    if (32'(s2_ctrl_q.sel) == k) acc_d[k] = bias_ext;
                OP_CLR:  for (int unsigned k = 0; k < NUM_ACC; k++)
                    acc_d[k] = '0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned k = 0; k < NUM_ACC; k++) acc_q[k] <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // GET readout: shift, ReLU, saturate to the output width, insert into pack word.
    always_comb begin
        ow   = 32;
        slot = 0;
        case (s2_ctrl_q.out_mode)
            2'b01:   begin ow = 8; slot = 32'(s2_ctrl_q.position[1:0]); end
            2'b10:   begin ow = 4; slot = 32'(s2_ctrl_q.position[2:0]); end
            2'b11:   begin ow = 2; slot = 32'(s2_ctrl_q.position);      end
            default: ;
        endcase
        shifted   = acc_rd >>> s2_ctrl_q.shift;
        v         = (s2_ctrl_q.relu && shifted[ACC_W-1]) ? '0 : shifted;
        sat_hi    = $signed((ACC_W'(1) << (ow - 1)) - ACC_W'(1));
        sat_lo    = ~sat_hi;
        field     = (v > sat_hi) ? sat_hi[31:0] : (v < sat_lo) ? sat_lo[31:0] : v[31:0];
        lane_mask = ((ow == 32) ? 32'hFFFF_FFFF : ((32'd1 << ow) - 32'd1)) << (slot * ow);
        get_res   = (s2_ctrl_q.out_mode == 2'b00) ? field
                  : (s2_ctrl_q.pack & ~lane_mask) | ((field << (slot * ow)) & lane_mask);
    end

    // S3: registered result; busy tracks whether any stage will hold an op.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            result_q    <= '0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            res_valid_q <= s2_valid_q && (s2_ctrl_q.op == OP_GET) && sel_ok;
            busy_q      <= op_valid_i | s1_valid_q | s2_valid_q;
            if (s2_valid_q && (s2_ctrl_q.op == OP_GET) && sel_ok) result_q <= get_res;
        end
    end

    assign result_o    = result_q;
    assign res_valid_o = res_valid_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_ibex_neur_mac_array.sv
// Scoreboard bench for ibex_neur_mac_array: ops update a plain-arithmetic
// accumulator model at issue, GET expectations are queued and checked on res_valid_o.
module tb_ibex_neur_mac_array;

    localparam int unsigned NUM_ACC = 4;
    localparam int unsigned ACC_W   = 40;
    localparam bit          SAT_ACC = 1'b1;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        op_valid_i;
    logic [1:0]  op_i, mode_i, out_mode_i;
    logic [1:0]  acc_sel_i;
    logic [31:0] weights_i, input_val_i, bias_i, pack_i;
    logic [4:0]  shift_i;
    logic        relu_en_i;
    logic [3:0]  position_i;
    logic [31:0] result_o;
    logic        res_valid_o, busy_o;

    ibex_neur_mac_array #(.NUM_ACC(NUM_ACC), .ACC_W(ACC_W), .SAT_ACC(SAT_ACC)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .op_valid_i(op_valid_i), .op_i(op_i),
        .mode_i(mode_i), .acc_sel_i(acc_sel_i), .weights_i(weights_i),
        .input_val_i(input_val_i), .bias_i(bias_i), .shift_i(shift_i),
        .relu_en_i(relu_en_i), .out_mode_i(out_mode_i), .position_i(position_i),
        .pack_i(pack_i), .result_o(result_o), .res_valid_o(res_valid_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] val;
        int unsigned due;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int unsigned n_cmp = 0, n_bad = 0, cyc = 0;
    longint      macc[NUM_ACC];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every result pulse must match the oldest queued GET, on time.
    always @(negedge clk) begin
        if (res_valid_o === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_result: got %h with nothing outstanding", result_o);
            end else begin
                e = sb.pop_front();
                check("get_result", result_o, e.val);
                check("get_latency", cyc, e.due);
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic longint sx(input longint v, input int w);
        longint m;
        m = v & ((longint'(1) << w) - 1);
        if (m >= (longint'(1) << (w - 1))) m -= (longint'(1) << w);
        return m;
    endfunction

    function automatic longint model_sum(input logic [1:0] mode, input logic [31:0] w, input logic [31:0] x);
        int     lw;
        longint s;
        lw = 16 >> mode;
        s  = 0;
        for (int i = 0; i < 32 / lw; i++)
            s += sx(longint'(w >> (i * lw)), lw) * sx(longint'(x >> (i * lw)), lw);
        return s;
    endfunction

    function automatic logic [31:0] model_get(input longint a, input int sh, input bit relu,
                                              input int om, input int pos, input logic [31:0] pack);
        longint      v, hi;
        int          w, slot;
        logic [31:0] f, r;
        v = a >>> sh;
        if (relu && v < 0) v = 0;
        w  = (om == 0) ? 32 : (om == 1) ? 8 : (om == 2) ? 4 : 2;
        hi = (longint'(1) << (w - 1)) - 1;
        if (v > hi) v = hi;
        if (v < -hi - 1) v = -hi - 1;
        f = 32'(v);
        if (om == 0) return f;
        slot = pos % (32 / w);
        r = pack;
        for (int b = 0; b < w; b++) r[slot * w + b] = f[b];
        return r;
    endfunction

    // ---------------- drivers ----------------
    task automatic drive(input logic [1:0] op, input logic [1:0] mode, input int sel,
                         input logic [31:0] w, input logic [31:0] x, input logic [31:0] b,
                         input logic [4:0] sh, input logic relu, input logic [1:0] om,
                         input logic [3:0] pos, input logic [31:0] pack);
        @(posedge clk);
        #1;
        op_valid_i = 1'b1; op_i = op; mode_i = mode; acc_sel_i = 2'(sel);
        weights_i = w; input_val_i = x; bias_i = b; shift_i = sh; relu_en_i = relu;
        out_mode_i = om; position_i = pos; pack_i = pack;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        op_valid_i = 1'b0;
    endtask

    task automatic mac(input int sel, input logic [1:0] mode, input logic [31:0] w, input logic [31:0] x);
        longint a, amax;
        amax = (longint'(1) << (ACC_W - 1)) - 1;
        a = macc[sel] + model_sum(mode, w, x);
        if (SAT_ACC) begin
            if (a > amax) a = amax;
            if (a < -amax - 1) a = -amax - 1;
        end else begin
            a = sx(a, ACC_W);
        end
        macc[sel] = a;
        drive(2'b00, mode, sel, w, x, $urandom, 5'($urandom), 1'($urandom), 2'($urandom),
              4'($urandom), $urandom);
    endtask

    task automatic bias(input int sel, input logic [31:0] b);
        macc[sel] = longint'($signed(b));
        drive(2'b01, 2'($urandom), sel, $urandom, $urandom, b, 5'($urandom), 1'($urandom),
              2'($urandom), 4'($urandom), $urandom);
    endtask

    task automatic clr();
        for (int i = 0; i < NUM_ACC; i++) macc[i] = 0;
        drive(2'b11, 2'($urandom), $urandom_range(0, NUM_ACC - 1), $urandom, $urandom, $urandom,
              5'($urandom), 1'($urandom), 2'($urandom), 4'($urandom), $urandom);
    endtask

    task automatic get(input int sel, input int sh, input bit relu, input int om, input int pos,
                       input logic [31:0] pack, input bit use_c, input logic [31:0] cval,
                       input bit track);
        exp_t x;
        x.val = use_c ? cval : model_get(macc[sel], sh, relu, om, pos, pack);
        drive(2'b10, 2'($urandom), sel, $urandom, $urandom, $urandom, 5'(sh), relu, 2'(om),
              4'(pos), pack);
        x.due = cyc + 3;
        if (track) sb.push_back(x);
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
            sb.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni = 1'b0; op_valid_i = 1'b0; op_i = '0; mode_i = '0; acc_sel_i = '0;
        weights_i = '0; input_val_i = '0; bias_i = '0; shift_i = '0; relu_en_i = 1'b0;
        out_mode_i = '0; position_i = '0; pack_i = '0;
        for (int i = 0; i < NUM_ACC; i++) macc[i] = 0;
        repeat (3) @(negedge clk);
        check("reset_result", result_o, 32'h0);
        check("reset_valid", 32'(res_valid_o), 32'h0);
        check("reset_busy", 32'(busy_o), 32'h0);
        rst_ni = 1'b1;

        // Basic 8b MAC, back-to-back GET, latency and busy.
        bias(0, 32'd5);
        mac(0, 2'b01, 32'h01020304, 32'h01010101);
        get(0, 0, 0, 0, 7, $urandom, 1, 32'd15, 1);
        idle();
        @(negedge clk);
        check("busy_active", 32'(busy_o), 32'h1);
        drain();
        check("busy_drained", 32'(busy_o), 32'h0);

        // 2b lanes, ReLU and 4b packing.
        bias(1, 32'd0);
        mac(1, 2'b11, 32'hFFFF_FFFF, 32'h5555_5555);
        get(1, 0, 1, 0, 0, $urandom, 1, 32'h0, 1);
        get(1, 0, 0, 2, 3, 32'h0, 1, 32'h0000_8000, 1);
        idle();
        drain();

        // Accumulator saturation.
        bias(2, 32'd0);
        for (int i = 0; i < 300; i++) mac(2, 2'b00, 32'h8000_8000, 32'h8000_8000);
        get(2, 0, 0, 0, 0, $urandom, SAT_ACC, 32'h7FFF_FFFF, 1);
        idle();
        drain();

        // Independent accumulators, then CLR.
        for (int r = 0; r < 6; r++)
            for (int s = 0; s < NUM_ACC; s++) mac(s, 2'($urandom), $urandom, $urandom);
        for (int s = 0; s < NUM_ACC; s++) get(s, 0, 0, 0, 0, $urandom, 0, 32'h0, 1);
        clr();
        get(3, 0, 0, 0, 0, $urandom, 1, 32'h0, 1);
        idle();
        drain();

        // Shift and 8b packing, in range and saturating.
        bias(0, 32'h1F0);
        get(0, 4, 0, 1, 5, 32'hAABB_CCDD, 1, 32'hAABB_1FDD, 1);
        bias(0, 32'h1F00);
        get(0, 4, 1, 1, 5, 32'hAABB_CCDD, 1, 32'hAABB_7FDD, 1);
        idle();
        drain();

        // Reset while a GET is in S2, with an op presented during reset.
        get(0, 0, 0, 0, 0, $urandom, 0, 32'h0, 0);
        idle();
        @(posedge clk);
        #2;
        rst_ni = 1'b0;
        op_valid_i = 1'b1; op_i = 2'b10; acc_sel_i = 2'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_valid", 32'(res_valid_o), 32'h0);
            check("rst_busy", 32'(busy_o), 32'h0);
            check("rst_result", result_o, 32'h0);
        end
        op_valid_i = 1'b0;
        rst_ni = 1'b1;
        for (int i = 0; i < NUM_ACC; i++) macc[i] = 0;
        get(0, 0, 0, 0, 0, $urandom, 1, 32'h0, 1);
        bias(2, 32'hFFFF_FFF0);
        get(2, 2, 0, 0, 0, $urandom, 1, 32'hFFFF_FFFC, 1);
        idle();
        drain();

        // Randomized op stream against the model.
        for (int n = 0; n < 400; n++) begin
            int k, s;
            k = $urandom_range(0, 19);
            s = $urandom_range(0, NUM_ACC - 1);
            if (k < 10)       mac(s, 2'($urandom), $urandom, $urandom);
            else if (k < 12)  bias(s, $urandom);
            else if (k < 19)  get(s, $urandom_range(0, 31), 1'($urandom), $urandom_range(0, 3),
                                  $urandom_range(0, 15), $urandom, 0, 32'h0, 1);
            else              clr();
            if ($urandom_range(0, 7) == 0) idle();
        end
        idle();
        drain();
        check("busy_final", 32'(busy_o), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
